fetch_unit: RTL

- Instruction fetch stage sitting directly upstream of the instruction decoder.
- Owns the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel plus a response-valid return channel.
- Buffers returned instructions, each tagged with its PC, in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes buffered and in-flight instructions.

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/fetch_unit.sv | 91 +++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: word geometry, the
// default boot address and the {pc, inst} entry carried through the buffer.
package fetch_unit_pkg;
    localparam int          XLEN             = 32;
    localparam int          INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    // Canonical ADDI x0,x0,0 encoding, kept here for future bubble insertion.
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the memory request/response, decode handshake and redirect
// signals; master is the fetch unit, slave is the surrounding pipeline.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous buffer of {pc, inst} entries. Flush beats push; a pop in
// the flush cycle is simply absorbed by the clear.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);
    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [DEPTH-1:0] w_slot_we;
    logic          w_pop;

    assign w_pop = i_pop & (r_count != '0);

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot_we
        assign w_slot_we[gi] = i_push & ~i_flush & (r_wr_ptr == PW'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_slot_we[i]) r_mem[i] <= i_push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues in-order word requests with
// credit-based buffer reservation, and discards responses made stale by a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_live;
    logic [CW-1:0]   w_outstanding_next;
    logic [FCW-1:0]  w_fifo_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic [31:0]     w_reserved;
    logic            w_inst_valid;
    logic            w_pop;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_keep;
    logic [XLEN-1:0] w_redirect_pc;

    assign w_inst_valid = (w_fifo_count != '0);
    assign w_pop        = w_inst_valid & bus.inst_ready;
    assign w_live       = r_outstanding - r_drop;

    // Every request still expected to land counts against buffer space, so a
    // kept response always finds a free slot.
    assign w_reserved   = 32'(w_fifo_count) + 32'(w_live) - 32'(w_pop);
    assign w_req_valid  = ~reset
                        & (32'(r_outstanding) < 32'(MAX_OUTSTANDING))
                        & (w_reserved < 32'(FIFO_DEPTH));
    assign w_accept     = w_req_valid & bus.imem_req_ready;

    assign w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(bus.imem_rsp_valid);
    assign w_keep        = bus.imem_rsp_valid & ~bus.redirect_valid & (r_drop == '0);
    assign w_redirect_pc = align_pc(bus.redirect_pc);
    assign w_push_entry  = '{pc: r_rsp_pc, inst: bus.imem_rsp_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (bus.redirect_valid) begin
                // Everything still in flight after this edge belongs to the old stream.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop     <= w_outstanding_next;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'(INST_BYTES);
                if (bus.imem_rsp_valid) begin
                    if (r_drop != '0) r_drop   <= r_drop - CW'(1);
                    else              r_rsp_pc <= r_rsp_pc + 32'(INST_BYTES);
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_keep),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (bus.redirect_valid),
        .o_count     (w_fifo_count),
        .o_head      (w_head)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst_data      = w_head.inst;
    assign bus.inst_pc        = w_head.pc;
endmodule
